uprog_loader: RTL and testbench

Control-store loader for the micro-BESM CPU core: accepts a framed byte stream from the host/debug port, assembles full-width micro-instruction words and writes them into microprogram memory at sequential addresses. It produces the micro-instruction images that the sequencer fetches and the trace monitor decodes. It sits between the host byte interface and the control-store write port, and is active only while the CPU is held in reset or halted.

---
 rtl/uprog_loader_pkg.sv | 16 +
 rtl/uprog_loader_if.sv | 23 ++
 rtl/uprog_loader.sv | 114 +++++++++++
 tb/tb_uprog_loader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uprog_loader_pkg.sv
// Shared types and constants for the micro-BESM control-store loader.
package uprog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    AH,
    AL,
    CH,
    CL,
    DATA,
    CSUM
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uprog_loader_if.sv
// Host byte stream plus control-store write port of the loader.
interface uprog_loader_if #(
  parameter int WORD_W = 112,
  parameter int ADDR_W = 12
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              cs_we;
  logic [ADDR_W-1:0] cs_addr;
  logic [WORD_W-1:0] cs_wdata;

  // master: host side that supplies bytes and observes the control-store writes
  modport master (
    output in_data, in_valid,
    input  in_ready, cs_we, cs_addr, cs_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, cs_we, cs_addr, cs_wdata
  );
endinterface

// File: rtl/uprog_loader.sv
// Control-store loader: parses SYNC/addr/count/data/checksum frames from the
// host byte port and writes assembled micro-instruction words sequentially.
module uprog_loader
  import uprog_loader_pkg::*;
#(
  parameter int WORD_W = 112,
  parameter int ADDR_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  uprog_loader_if.slave    bus,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int BYTES  = WORD_W / 8;
  localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  state_t              state;
  logic [WORD_W-9:0]   word_q;     // all bytes of the word except the last one
  logic [BCNT_W-1:0]   bcnt;
  logic [15:0]         wcnt;
  logic [7:0]          sum;
  logic [7:0]          addr_h;
  logic [ADDR_W-1:0]   waddr;
  logic                cs_we_q;
  logic [ADDR_W-1:0]   cs_addr_q;
  logic [WORD_W-1:0]   cs_wdata_q;

  logic                acc;
  logic [7:0]          sum_next;

  assign acc      = bus.in_valid & en;
  assign sum_next = sum + bus.in_data;

  assign bus.in_ready = en;
  assign bus.cs_we    = cs_we_q;
  assign bus.cs_addr  = cs_addr_q;
  assign bus.cs_wdata = cs_wdata_q;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      word_q     <= '0;
      bcnt       <= '0;
      wcnt       <= '0;
      sum        <= '0;
      addr_h     <= '0;
      waddr      <= '0;
      cs_we_q    <= 1'b0;
      cs_addr_q  <= '0;
      cs_wdata_q <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      cs_we_q <= 1'b0;
      done    <= 1'b0;
      if (acc) begin
        if (state != IDLE) sum <= sum_next;
        case (state)
          IDLE: begin
            if (bus.in_data == SYNC_BYTE) begin
              state <= AH;
              err   <= 1'b0;
              sum   <= '0;
              bcnt  <= '0;
            end
          end
          AH: begin
            addr_h <= bus.in_data;
            state  <= AL;
          end
          AL: begin
            waddr <= ADDR_W'({addr_h, bus.in_data});
            state <= CH;
          end
          CH: begin
            wcnt[15:8] <= bus.in_data;
            state      <= CL;
          end
          CL: begin
            wcnt[7:0] <= bus.in_data;
            state     <= ({wcnt[15:8], bus.in_data} != 16'd0) ? DATA : CSUM;
          end
          DATA: begin
            if (bcnt == BCNT_W'(BYTES - 1)) begin
              // word complete: commit it even though the checksum is still unknown
              bcnt       <= '0;
              cs_we_q    <= 1'b1;
              cs_addr_q  <= waddr;
              cs_wdata_q <= {word_q, bus.in_data};
              waddr      <= waddr + 1'b1;
              wcnt       <= wcnt - 16'd1;
              if (wcnt == 16'd1) state <= CSUM;
            end else begin
              bcnt   <= bcnt + 1'b1;
              word_q <= {word_q[WORD_W-17:0], bus.in_data};
            end
          end
          CSUM: begin
            state <= IDLE;
            if (sum_next == 8'd0) done <= 1'b1;
            else                  err  <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uprog_loader.sv
// Self-checking bench for uprog_loader: idle-state vector table, directed
// frames, randomized frames with gaps, and a mid-word reset.
module tb_uprog_loader;
  localparam int WORD_W = 112;
  localparam int ADDR_W = 12;
  localparam int BYTES  = WORD_W / 8;

  typedef logic [WORD_W-1:0] word_t;

  logic clk = 1'b0;
  logic reset;
  logic en;
  logic busy, done, err;

  uprog_loader_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

  uprog_loader #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // write / done monitor
  int cyc = 0;
  int done_cnt = 0;
  logic [ADDR_W-1:0] wr_addr_q[$];
  word_t             wr_data_q[$];
  int                wr_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.cs_we) begin
      wr_addr_q.push_back(bus.cs_addr);
      wr_data_q.push_back(bus.cs_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one byte, optionally preceded by random stall cycles where either
  // in_valid is low or en is low (with garbage on the bus).
  task automatic send_byte(input logic [7:0] b, input int gaps_max);
    int gaps;
    gaps = (gaps_max == 0) ? 0 : int'($urandom_range(0, gaps_max));
    for (int g = 0; g < gaps; g++) begin
      if ($urandom_range(0, 1) == 1) begin
        en = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'($urandom);
      end else begin
        en = 1'b1; bus.in_valid = 1'b0; bus.in_data = 8'($urandom);
      end
      step();
    end
    en = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    step();
    bus.in_valid = 1'b0;
  endtask

  // Reference model: frame bytes built straight from the frame format.
  logic [7:0] frame_q[$];
  word_t      words_q[$];

  task automatic build_frame(input logic [15:0] a16, input int bump);
    int unsigned s;
    logic [7:0] b;
    logic [15:0] n;
    frame_q.delete();
    s = 0;
    n = 16'(words_q.size());
    frame_q.push_back(8'hA5);
    frame_q.push_back(a16[15:8]); s += a16[15:8];
    frame_q.push_back(a16[7:0]);  s += a16[7:0];
    frame_q.push_back(n[15:8]);   s += n[15:8];
    frame_q.push_back(n[7:0]);    s += n[7:0];
    foreach (words_q[i]) begin
      for (int j = 0; j < BYTES; j++) begin
        b = 8'(words_q[i] >> (8 * (BYTES - 1 - j)));
        frame_q.push_back(b);
        s += b;
      end
    end
    frame_q.push_back(8'((256 - (s % 256) + unsigned'(bump)) % 256));
  endtask

  task automatic run_frame(input string tag, input logic [15:0] a16, input int bump,
                           input int gaps_max, input bit check_rate);
    int w0, d0, n;
    int unsigned base;
    w0 = wr_addr_q.size();
    d0 = done_cnt;
    n  = words_q.size();
    build_frame(a16, bump);
    foreach (frame_q[k]) send_byte(frame_q[k], gaps_max);
    chk({tag, "_done_now"}, 128'(done), 128'(bump == 0));
    chk({tag, "_err_now"},  128'(err),  128'(bump != 0));
    chk({tag, "_busy_end"}, 128'(busy), 128'(0));
    step();
    chk({tag, "_done_one_cycle"}, 128'(done), 128'(0));
    repeat (2) step();
    chk({tag, "_wr_count"}, 128'(wr_addr_q.size() - w0), 128'(n));
    chk({tag, "_done_pulses"}, 128'(done_cnt - d0), 128'(bump == 0));
    base = unsigned'(int'(a16)) % (1 << ADDR_W);
    for (int i = 0; i < n && (w0 + i) < wr_addr_q.size(); i++) begin
      chk({tag, "_wr_addr"}, 128'(wr_addr_q[w0 + i]), 128'((base + unsigned'(i)) % (1 << ADDR_W)));
      chk({tag, "_wr_data"}, 128'(wr_data_q[w0 + i]), 128'(words_q[i]));
      if (check_rate && i > 0)
        chk({tag, "_wr_spacing"}, 128'(wr_cyc_q[w0 + i] - wr_cyc_q[w0 + i - 1]), 128'(BYTES));
    end
  endtask

  typedef struct {
    logic       en;
    logic       valid;
    logic [7:0] data;
    logic       exp_ready;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[6];

  word_t w0_c, w1_c;

  initial begin
    vecs[0] = '{en: 1'b1, valid: 1'b1, data: 8'h00, exp_ready: 1'b1, exp_busy: 1'b0};
    vecs[1] = '{en: 1'b1, valid: 1'b1, data: 8'h5A, exp_ready: 1'b1, exp_busy: 1'b0};
    vecs[2] = '{en: 1'b0, valid: 1'b1, data: 8'hA5, exp_ready: 1'b0, exp_busy: 1'b0};
    vecs[3] = '{en: 1'b1, valid: 1'b0, data: 8'hA5, exp_ready: 1'b1, exp_busy: 1'b0};
    vecs[4] = '{en: 1'b1, valid: 1'b1, data: 8'hFF, exp_ready: 1'b1, exp_busy: 1'b0};
    vecs[5] = '{en: 1'b1, valid: 1'b1, data: 8'hA5, exp_ready: 1'b1, exp_busy: 1'b1};

    w0_c = 112'hA5A5_0123_4567_89AB_CDEF_FEDC_BA98;
    w1_c = 112'h1122_3344_5566_7788_99AA_BBCC_DDEE;

    reset = 1'b1; en = 1'b1; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    repeat (3) step();
    chk("rst_cs_we",    128'(bus.cs_we),    128'(0));
    chk("rst_cs_addr",  128'(bus.cs_addr),  128'(0));
    chk("rst_cs_wdata", 128'(bus.cs_wdata), 128'(0));
    chk("rst_busy",     128'(busy),         128'(0));
    chk("rst_done",     128'(done),         128'(0));
    chk("rst_err",      128'(err),          128'(0));
    chk("rst_ready_en1", 128'(bus.in_ready), 128'(1));
    en = 1'b0; #1;
    chk("rst_ready_en0", 128'(bus.in_ready), 128'(0));
    reset = 1'b0; en = 1'b1;
    step();

    // idle-state vector table: garbage ignored, SYNC only taken when accepted
    for (int i = 0; i < 6; i++) begin
      en = vecs[i].en; bus.in_valid = vecs[i].valid; bus.in_data = vecs[i].data;
      #1;
      chk("tbl_ready", 128'(bus.in_ready), 128'(vecs[i].exp_ready));
      step();
      chk("tbl_busy", 128'(busy), 128'(vecs[i].exp_busy));
    end
    bus.in_valid = 1'b0; en = 1'b1;
    reset = 1'b1; step(); reset = 1'b0; step();

    // basic two-word frame at full rate
    words_q.delete(); words_q.push_back(w0_c); words_q.push_back(w1_c);
    run_frame("basic", 16'h0010, 0, 0, 1'b1);

    // bad checksum: writes survive, err set, cleared by the next SYNC
    run_frame("badsum", 16'h0010, 1, 0, 1'b1);
    send_byte(8'hA5, 0);
    chk("err_clear_on_sync", 128'(err), 128'(0));
    chk("busy_after_sync", 128'(busy), 128'(1));

    // finish that frame as an N=0 frame: no writes, done pulse
    begin
      int wb, db;
      wb = wr_addr_q.size(); db = done_cnt;
      words_q.delete();
      build_frame(16'h0123, 0);
      void'(frame_q.pop_front());
      foreach (frame_q[k]) send_byte(frame_q[k], 0);
      chk("n0_done_now", 128'(done), 128'(1));
      repeat (3) step();
      chk("n0_no_writes", 128'(wr_addr_q.size() - wb), 128'(0));
      chk("n0_done_pulses", 128'(done_cnt - db), 128'(1));
    end

    // address wrap
    words_q.delete(); words_q.push_back(w1_c); words_q.push_back(w0_c);
    run_frame("wrap", 16'h0FFF, 0, 0, 1'b1);

    // same frame as basic with random gaps and en toggling
    words_q.delete(); words_q.push_back(w0_c); words_q.push_back(w1_c);
    run_frame("gaps", 16'h0010, 0, 3, 1'b0);

    // reset on the edge that accepts the 14th data byte
    begin
      int wb;
      wb = wr_addr_q.size();
      words_q.delete(); words_q.push_back(w1_c);
      build_frame(16'h0055, 0);
      for (int k = 0; k < 5 + BYTES - 1; k++) send_byte(frame_q[k], 0);
      en = 1'b1; bus.in_valid = 1'b1; bus.in_data = frame_q[5 + BYTES - 1];
      reset = 1'b1;
      step();
      reset = 1'b0; bus.in_valid = 1'b0;
      chk("midrst_cs_we",    128'(bus.cs_we),    128'(0));
      chk("midrst_busy",     128'(busy),         128'(0));
      chk("midrst_cs_addr",  128'(bus.cs_addr),  128'(0));
      chk("midrst_cs_wdata", 128'(bus.cs_wdata), 128'(0));
      chk("midrst_done",     128'(done),         128'(0));
      chk("midrst_err",      128'(err),          128'(0));
      repeat (3) step();
      chk("midrst_no_write", 128'(wr_addr_q.size() - wb), 128'(0));
    end

    // randomized frames against the model
    for (int f = 0; f < 8; f++) begin
      int n, bump;
      words_q.delete();
      n = int'($urandom_range(0, 3));
      for (int i = 0; i < n; i++)
        words_q.push_back(word_t'({$urandom, $urandom, $urandom, $urandom}));
      bump = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 255)) : 0;
      run_frame("rand", 16'($urandom), bump, 2, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
